// File: rtl/rc5_decrypt_core.sv
// Iterative RC5-16/r/16 decryption engine: on-chip key expansion, then one round per clock.
// Optional macro RC5_DEC_KEY_CACHE_EN reuses the expanded key when key/num_rounds repeat.
module rc5_decrypt_core #(
  parameter int W          = 16,
  parameter int MAX_ROUNDS = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         decrypt,
  input  logic [4:0]   num_rounds,
  input  logic [127:0] key,
  input  logic [31:0]  d_in,
  output logic [31:0]  d_out,
  output logic         done,
  output logic         busy
);

  localparam int SD = 2 * MAX_ROUNDS + 2;

  // Handshake: decrypt is sampled only in IDLE (ignored while busy, no queueing);
  // done pulses for one cycle when d_out is valid, and d_out holds until replaced.
  typedef enum logic [2:0] {IDLE, LOAD, MIX, ROUND, FINAL, DONE} state_t;
  state_t state, state_nxt;

  logic [W-1:0] s_mem [SD];
  logic [W-1:0] l_mem [8];
  logic [W-1:0] x_q, y_q, a_q, b_q, p_q;
  logic [4:0]   r_q, k_q, r_eff;
  logic [5:0]   i_q;
  logic [2:0]   j_q;
  logic [7:0]   cnt;
  logic [6:0]   t_q;
  logic [7:0]   mix_total;
  logic         i_wrap, mix_last;
  logic [W-1:0] mix_sum, x_new, xy_sum, y_new, a_new, b_new;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] v, input logic [3:0] s);
    logic [2*W-1:0] d;
    d = {v, v} << s;
    return d[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input logic [3:0] s);
    logic [2*W-1:0] d;
    d = {v, v} >> s;
    return d[W-1:0];
  endfunction

  generate
    if (MAX_ROUNDS < 31) begin : g_clamp
      assign r_eff = (num_rounds > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : num_rounds;
    end else begin : g_noclamp
      assign r_eff = num_rounds;
    end
  endgenerate

  assign t_q       = {1'b0, r_q, 1'b0} + 7'd2;
  assign mix_total = (t_q < 7'd8) ? 8'd24 : ({1'b0, t_q} * 8'd3);
  assign i_wrap    = (7'(i_q) == t_q - 7'd1);
  assign mix_last  = (cnt == mix_total - 8'd1);

`ifdef RC5_DEC_KEY_CACHE_EN
  logic         cache_valid;
  logic [127:0] cache_key;
  logic [4:0]   cache_rounds;
  logic         cache_hit;
  assign cache_hit = cache_valid && (key == cache_key) && (r_eff == cache_rounds);
`endif

  always_comb begin
    mix_sum = s_mem[i_q] + x_q + y_q;
    x_new   = rotl(mix_sum, 4'd3);
    xy_sum  = x_new + y_q;
    y_new   = rotl(l_mem[j_q] + xy_sum, xy_sum[3:0]);
    b_new   = rotr(b_q - s_mem[{k_q, 1'b1}], a_q[3:0]) ^ a_q;
    a_new   = rotr(a_q - s_mem[{k_q, 1'b0}], b_new[3:0]) ^ b_new;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (decrypt) begin
`ifdef RC5_DEC_KEY_CACHE_EN
          if (cache_hit) state_nxt = (r_eff == 5'd0) ? FINAL : ROUND;
          else           state_nxt = LOAD;
`else
          state_nxt = LOAD;
`endif
        end
      end
      LOAD:  if (i_wrap) state_nxt = MIX;
      MIX:   if (mix_last) state_nxt = (r_q == 5'd0) ? FINAL : ROUND;
      ROUND: if (k_q == 5'd1) state_nxt = FINAL;
      FINAL: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Subkey and key-word tables carry no reset; their contents are rebuilt before use.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (decrypt) for (int n = 0; n < 8; n++) l_mem[n] <= key[W*n +: W];
      LOAD: s_mem[i_q] <= p_q;
      MIX: begin
        s_mem[i_q] <= x_new;
        l_mem[j_q] <= y_new;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= '0;
      r_q   <= '0;
      k_q   <= '0;
      i_q   <= '0;
      j_q   <= '0;
      cnt   <= '0;
      x_q   <= '0;
      y_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
`ifdef RC5_DEC_KEY_CACHE_EN
      cache_valid  <= 1'b0;
      cache_key    <= '0;
      cache_rounds <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (decrypt) begin
            r_q <= r_eff;
            k_q <= r_eff;
            a_q <= d_in[15:0];
            b_q <= d_in[31:16];
            i_q <= '0;
            j_q <= '0;
            cnt <= '0;
            x_q <= '0;
            y_q <= '0;
            p_q <= W'(16'hB7E1);
`ifdef RC5_DEC_KEY_CACHE_EN
            // A miss rebuilds S, so the cached schedule is gone from here on.
            if (!cache_hit) begin
              cache_valid  <= 1'b0;
              cache_key    <= key;
              cache_rounds <= r_eff;
            end
`endif
          end
        end
        LOAD: begin
          p_q <= p_q + W'(16'h9E37);
          i_q <= i_wrap ? 6'd0 : i_q + 6'd1;
        end
        MIX: begin
          x_q <= x_new;
          y_q <= y_new;
          i_q <= i_wrap ? 6'd0 : i_q + 6'd1;
          j_q <= j_q + 3'd1;
          cnt <= cnt + 8'd1;
`ifdef RC5_DEC_KEY_CACHE_EN
          if (mix_last) cache_valid <= 1'b1;
`endif
        end
        ROUND: begin
          b_q <= b_new;
          a_q <= a_new;
          k_q <= k_q - 5'd1;
        end
        FINAL: d_out <= {b_q - s_mem[1], a_q - s_mem[0]};
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rc5_decrypt_core.md
Name: rc5_decrypt_core

Overview:
- Iterative RC5-16/r/16 decryption engine: 32-bit block, 16-bit words, 128-bit key, 0..31 rounds.
- Inverse of the accelerator's encrypt datapath. It shares that path's key/round/data interface, so the top-level controller can route decrypt requests here.
- Performs its own key expansion into an internal subkey table S, then runs one decryption round per clock.

Parameters:
- W, 16, word width (fixed by block size; only 16 supported)
- MAX_ROUNDS, 31, upper bound on num_rounds; S depth = 2*MAX_ROUNDS+2 = 64

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- decrypt  in  1  start request; sampled only in IDLE
- num_rounds  in  5  round count r, latched at start
- key  in  128  key bytes K[0]=key[7:0] .. K[15]=key[127:120], latched at start
- d_in  in  32  ciphertext {B,A}: A=d_in[15:0], B=d_in[31:16], latched at start
- d_out  out  32  plaintext {B,A}, valid while done=1, held until next start
- done  out  1  one-cycle pulse when d_out becomes valid
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, d_out=0, done=0, busy=0, round/index counters=0. S contents don't care.
- States: IDLE -> LOAD -> MIX -> ROUND -> FINAL -> DONE -> IDLE.
- IDLE:
  - decrypt=1 latches key, num_rounds, d_in; sets t=2r+2.
  - Starts a transaction unconditionally (see KEY_CACHE_EN).
- LOAD: t cycles, one write per cycle: S[0]=0xB7E1, S[i]=S[i-1]+0x9E37 (mod 2^16).
- MIX: 3*max(t,8) cycles, one step per cycle. L[j]={K[2j+1],K[2j]}, j=0..7; X=Y=i=j=0 at entry. Each step:
  - X=S[i]=rotl(S[i]+X+Y,3)
  - Y=L[j]=rotl(L[j]+X+Y, (X+Y)[3:0]), using the new X
  - i=(i+1) mod t; j=(j+1) mod 8
- ROUND: r cycles, k=r down to 1:
  - B=rotr(B-S[2k+1], A[3:0]) ^ A
  - A=rotr(A-S[2k], B[3:0]) ^ B, using the new B
  - r=0 skips ROUND entirely (MIX goes straight to FINAL).
- FINAL: 1 cycle: B=B-S[1]; A=A-S[0]; d_out<={B,A}.
- DONE: 1 cycle: done=1, busy=1; next state IDLE.
- Arithmetic: all add/sub mod 2^16; rotate amount = low 4 bits only.
- Latency from the IDLE edge that samples decrypt=1 to done=1: exactly t + 3*max(t,8) + r + 1 cycles.
  - r=12: 26+78+12+1 = 117
  - r=0: 2+24+0+1 = 27
- Boundary conditions:
  - decrypt asserted while busy: ignored, no queueing; inputs may change freely while busy.
  - decrypt held high through DONE: a new transaction starts on the first IDLE cycle.
  - rst low mid-operation: immediate return to IDLE, outputs cleared, partial result discarded.
  - num_rounds > MAX_ROUNDS (only if MAX_ROUNDS < 31): clamped to MAX_ROUNDS.

Optional Feature:
- Macro: RC5_DEC_KEY_CACHE_EN
- Defined:
  - Core keeps the last expanded key, the last num_rounds, and a cache_valid flag (cleared by reset).
  - On start, if cache_valid and key/num_rounds match, IDLE goes directly to ROUND (or FINAL when r=0), reusing S.
  - Latency on a hit = r+1.
  - A completed MIX sets cache_valid; reset or a mid-MIX abort clears it.
- Not defined: no cache registers; every start runs LOAD and MIX; latency is always the full formula.

Test Plan:
- Reset then idle: rst=0 for 3 cycles, release -> d_out=0x00000000, done=0, busy=0; no done pulse over 200 cycles.
- Golden vector, r=12: key=0x0F0E0D0C0B0A09080706050403020100, d_in = C-model encrypt of 0x12345678 -> done exactly 117 cycles after start, d_out=0x12345678, busy drops the cycle after done.
- Zero rounds: r=0, key=0, d_in=0xA5A5A5A5 -> done at 27 cycles; d_out equals C-model decrypt; round-trip with the encrypt model returns 0xA5A5A5A5.
- Busy/abort: start r=31 (t=64), assert decrypt again at cycle 50 -> ignored, single done at 64+192+31+1 = 288. Pull rst low at cycle 100 of a second run -> busy=0 and d_out=0 asynchronously, no done.
- Key cache, RC5_DEC_KEY_CACHE_EN defined: two back-to-back r=12 starts with the same key -> first done at 117, second at 13, both correct. Third start with key bit 0 flipped -> 117.
- Random sweep: 500 random {key, r in 0..31, d_in} round-trips against the C model -> all d_out match; each latency matches the formula.
